debounce_multi: RTL
===================

// Module: debounce_multi
// PURPOSE
//  Debounces NUM_KEYS asynchronous push-buttons. All channels share one sample-tick
//  divider; each channel has a synchroniser, a stability counter and a 4-state FSM.
//  Per channel it delivers a clean level plus one-cycle press/release strobes.
//  Sits between board keys and the watch control FSM (mode/set/adjust).
// PARAMETERS
//  NUM_KEYS      4       number of independent key channels (>=1)
//  TICK_DIV      500000  clk_i cycles per sample tick (>=2)
//  STABLE_TICKS  2       consecutive agreeing ticks needed to accept a change (>=1)
//  LONG_TICKS    200     ticks held before long_o fires (only with DEBOUNCE_LONGPRESS_EN; >=1)
// PORTS
//  clk_i      in   1         system clock
//  rstn_i     in   1         asynchronous active-low reset
//  key_i      in   NUM_KEYS  raw async key inputs, active-high
//  level_o    out  NUM_KEYS  debounced level, 1 = pressed
//  press_o    out  NUM_KEYS  1-cycle strobe on accepted press
//  release_o  out  NUM_KEYS  1-cycle strobe on accepted release
//  long_o     out  NUM_KEYS  1-cycle strobe on long-press threshold
//  tick_o     out  1         shared sample tick, for debug/other users
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, divider 0, FSMs IDLE,
//    counters 0, synchroniser flops 0. Reset mid-bounce discards all progress.
//  - Divider: counts 0..TICK_DIV-1, wraps to 0. tick_o=1 for exactly the cycle count==TICK_DIV-1.
//    Width $clog2(TICK_DIV); no overflow past TICK_DIV-1.
//  - Synchroniser: 2 flops per channel; FSM sees only the synchronised sample s.
//  - FSM runs only on tick_o=1; otherwise it holds state. Stability counter cnt has
//    width $clog2(STABLE_TICKS+1).
//    IDLE:  s=1 -> PRESS_PEND, cnt=1 (if STABLE_TICKS==1, go straight to HELD).
//    PRESS_PEND: s=1 -> cnt++; when cnt reaches STABLE_TICKS -> HELD. s=0 -> IDLE, cnt=0.
//    HELD:  s=0 -> REL_PEND, cnt=1 (STABLE_TICKS==1: straight to IDLE).
//    REL_PEND: s=0 -> cnt++; when cnt reaches STABLE_TICKS -> IDLE. s=1 -> HELD, cnt=0.
//  - level_o=1 in HELD and REL_PEND; level_o=0 in IDLE and PRESS_PEND (all registered).
//  - press_o pulses in the cycle after the tick that enters HELD from PRESS_PEND/IDLE.
//    release_o pulses in the cycle after the tick that enters IDLE from REL_PEND/HELD.
//    level_o changes in the same cycle as the strobe.
//  - A bounce shorter than STABLE_TICKS ticks produces no strobe and no level change.
//  - Worst-case acceptance latency: 2 sync cycles + STABLE_TICKS*TICK_DIV + 1 cycles.
//  - Channels are fully independent. Simultaneous events on several channels give
//    simultaneous strobes.
// CONFIGURATION
//  DEBOUNCE_LONGPRESS_EN defined: each channel has a hold counter of width
//   $clog2(LONG_TICKS+1), cleared on entry to HELD from PRESS_PEND/IDLE, incremented on
//   every tick in HELD or REL_PEND, and saturating at LONG_TICKS. long_o pulses once,
//   on the cycle after the tick at which the counter reaches LONG_TICKS. It never
//   re-fires in the same press. A REL_PEND->HELD bounce does not clear the counter.
//  DEBOUNCE_LONGPRESS_EN undefined: no hold counter logic; long_o tied to 0; port kept.
// STRUCTURE
//  - debounce_pkg: typedef enum logic [1:0] {DB_IDLE, DB_PRESS_PEND, DB_HELD, DB_REL_PEND}
//    db_state_t; plus a localparam helper for counter widths.
//  - Sub-module debounce_chan: synchroniser, FSM, stability counter and optional hold
//    counter for one key. Takes tick as an input.
//  - debounce_multi: shared divider plus a generate loop of NUM_KEYS debounce_chan.
// TESTING (TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5, NUM_KEYS=4)
//  1. Reset with key_i=4'hF asserted -> all outputs 0; after release, tick_o every
//     4th cycle.
//  2. key_i[0] held 1 -> press_o[0] single pulse and level_o[0]=1 after the 3rd
//     agreeing tick, within 2+12+1 cycles.
//  3. key_i[1] high for 2 ticks then low -> no press_o[1]; level_o[1] stays 0.
//  4. Pressed key_i[2] glitches low for 1 tick -> no release_o[2]; a later 3-tick low
//     gives one release_o[2] pulse.
//  5. key_i[0] and key_i[3] rise together -> press_o=4'b1001 in the same cycle.
//  6. LONGPRESS_EN: key_i[0] held 20 ticks -> exactly one long_o[0], 5 ticks after
//     press_o[0]. Macro off: long_o stays 0.
//     Assert rstn_i in PRESS_PEND -> no strobe; FSM restarts from IDLE.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
// Optional feature macro: DEBOUNCE_LONGPRESS_EN (long-press strobe per channel).
package debounce_pkg;

  // Per-channel debounce state
  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_PEND,
    DB_HELD,
    DB_REL_PEND
  } db_state_t;

  // Bits needed to hold the values 0..max_val (never less than 1)
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, 4-state acceptance FSM with a
// stability counter, registered level/press/release outputs and, when
// DEBOUNCE_LONGPRESS_EN is defined, a saturating hold counter with long-press strobe.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 2,
  parameter int LONG_TICKS   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_press
);

  localparam int CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic      sync1_reg, sync2_reg;
  logic      s;
  db_state_t state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic      level_reg, press_reg, rel_reg;
  logic      enter_held, enter_idle;

  assign s = sync2_reg;

  // Two-flop synchroniser for the raw asynchronous key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
    end
  end

  // Decode the ticks on which a change is finally accepted
  always_comb begin
    enter_held = 1'b0;
    enter_idle = 1'b0;
    if (tick) begin
      case (state_reg)
        DB_IDLE:       enter_held = s && (STABLE_TICKS == 1);
        DB_PRESS_PEND: enter_held = s && (cnt_reg == CNT_LAST);
        DB_HELD:       enter_idle = !s && (STABLE_TICKS == 1);
        DB_REL_PEND:   enter_idle = !s && (cnt_reg == CNT_LAST);
        default:       ;
      endcase
    end
  end

  // Debounce FSM: advances only on sample ticks; strobes last one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DB_IDLE;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      rel_reg   <= 1'b0;
    end else begin
      press_reg <= enter_held;
      rel_reg   <= enter_idle;
      if (enter_held) begin
        level_reg <= 1'b1;
      end else if (enter_idle) begin
        level_reg <= 1'b0;
      end
      if (tick) begin
        case (state_reg)
          DB_IDLE: begin
            if (s) begin
              state_reg <= enter_held ? DB_HELD : DB_PRESS_PEND;
              cnt_reg   <= enter_held ? '0 : CNT_ONE;
            end
          end
          DB_PRESS_PEND: begin
            if (!s) begin
              state_reg <= DB_IDLE;
              cnt_reg   <= '0;
            end else if (enter_held) begin
              state_reg <= DB_HELD;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          DB_HELD: begin
            if (!s) begin
              state_reg <= enter_idle ? DB_IDLE : DB_REL_PEND;
              cnt_reg   <= enter_idle ? '0 : CNT_ONE;
            end
          end
          DB_REL_PEND: begin
            if (s) begin
              state_reg <= DB_HELD;
              cnt_reg   <= '0;
            end else if (enter_idle) begin
              state_reg <= DB_IDLE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_reg <= DB_IDLE;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;
  assign rel   = rel_reg;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int HOLD_W = cnt_width(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

  logic [HOLD_W-1:0] hold_reg;
  logic              long_reg;
  logic              in_hold;

  // A REL_PEND bounce back to HELD keeps counting: only a fresh press clears it
  assign in_hold = (state_reg == DB_HELD) || (state_reg == DB_REL_PEND);

  // Saturating hold counter; the strobe fires only on the tick it reaches the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= '0;
      long_reg <= 1'b0;
    end else begin
      long_reg <= 1'b0;
      if (enter_held) begin
        hold_reg <= '0;
      end else if (tick && in_hold && (hold_reg != HOLD_MAX)) begin
        hold_reg <= hold_reg + HOLD_ONE;
        long_reg <= (hold_reg == HOLD_LAST);
      end
    end
  end

  assign long_press = long_reg;
`else
  // Long-press disabled: output held low, parameter still referenced so both
  // builds share the same parameter list
  assign long_press = (LONG_TICKS > 0) & 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-key debouncer: one shared sample-tick divider feeding NUM_KEYS
// independent debounce_chan instances.
// Optional feature macro: DEBOUNCE_LONGPRESS_EN (per-channel long-press strobe).
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 2,
  parameter int LONG_TICKS   = 200
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NUM_KEYS-1:0] key_i,
  output logic [NUM_KEYS-1:0] level_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o,
  output logic [NUM_KEYS-1:0] long_o,
  output logic                tick_o
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_reg;
  logic             tick;

  assign tick   = (div_reg == DIV_LAST);
  assign tick_o = tick;

  // Shared divider: 0..TICK_DIV-1, wrapping on the tick cycle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_ONE;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
      debounce_chan #(
        .STABLE_TICKS(STABLE_TICKS),
        .LONG_TICKS  (LONG_TICKS)
      ) u_chan (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .tick      (tick),
        .key       (key_i[gi]),
        .level     (level_o[gi]),
        .press     (press_o[gi]),
        .rel       (release_o[gi]),
        .long_press(long_o[gi])
      );
    end
  endgenerate

endmodule
